fetch_unit: RTL

- Instruction-fetch stage producer. Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Presents the fetched instruction and PC+4 to the IF/ID pipeline register, which is the consumer.
- Honours the stall from hazard detection and branch/jump redirects from ID/EX, discarding wrong-path fetches.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    typedef logic [31:0] word_t;

    // sll $0,$0,0 -- the architectural bubble
    localparam word_t NOP_WORD = 32'h0000_0000;
    localparam word_t PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding to imem
        HOLD  = 2'd1,   // valid word presented, downstream stalled
        DRAIN = 2'd2    // wrong-path response still owed by imem
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/fetch_unit.sv
// Instruction-fetch producer: owns the PC, fetches from imem over req/ready and feeds IF/ID.
// Latency: 1 cycle from imem_ready to registered instruction/pc/valid; 1 instr/cycle with zero-wait imem.
// Backpressure: stall holds outputs; one response arriving under stall is parked in a 1-entry skid.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   stall                   IF/ID does not load this cycle
//   redirect, redirect_pc   taken branch / jump target (low two bits ignored)
//   imem_req, imem_addr     level request, address stable until imem_ready
//   imem_ready, imem_rdata  response strobe and instruction word
//   instruction, pc, valid  registered outputs to IF/ID (pc = fetch address + 4)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        valid
);
    import mips_pkg::*;

    fetch_state_e state_q, state_d;
    word_t        fetch_pc_q, fetch_pc_d;
    word_t        instr_q, instr_d;
    word_t        pc_q, pc_d;
    logic         valid_q, valid_d;
    logic         skid_vld_q, skid_vld_d;
    word_t        skid_instr_q, skid_instr_d;
    word_t        skid_pc_q, skid_pc_d;

    word_t        pc_plus4;

    // Wraps modulo 2^32 by width.
    assign pc_plus4 = fetch_pc_q + PC_INC;

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = fetch_pc_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign valid       = valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            instr_q      <= NOP_WORD;
            pc_q         <= 32'h0000_0000;
            valid_q      <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= NOP_WORD;
            skid_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redirect) begin
            // Redirect outranks stall and imem_ready in every state.
            fetch_pc_d = redirect_pc & ~32'h0000_0003;
            valid_d    = 1'b0;
            instr_d    = NOP_WORD;
            skid_vld_d = 1'b0;
            unique case (state_q)
                // A request still in flight must be swallowed before refetching.
                FETCH:   state_d = imem_ready ? FETCH : DRAIN;
                HOLD:    state_d = FETCH;
                DRAIN:   state_d = DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        fetch_pc_d = pc_plus4;
                        if (stall && valid_q) begin
                            // Current outputs not consumed: park the new word.
                            skid_vld_d   = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_plus4;
                            state_d      = HOLD;
                        end else begin
                            // Outputs empty or being consumed: load directly.
                            instr_d = imem_rdata;
                            pc_d    = pc_plus4;
                            valid_d = 1'b1;
                            state_d = stall ? HOLD : FETCH;
                        end
                    end else if (!stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (skid_vld_q) begin
                            instr_d    = skid_instr_q;
                            pc_d       = skid_pc_q;
                            valid_d    = 1'b1;
                            skid_vld_d = 1'b0;
                        end
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    // The owed wrong-path response is dropped here.
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule : fetch_unit
